// File: rtl/lcd_pkg.sv
// lcd_pkg: command codes, FSM states and sizing helpers shared by the LCD window controller
package lcd_pkg;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_HOME    = 3'd6;
    localparam logic [2:0] CMD_MIRROR  = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    // bits needed to hold 0..max_val, never less than one bit
    function automatic int bits_for(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // centred origin along one axis
    function automatic int origin0(input int img, input int win);
        return (img - win + 1) / 2;
    endfunction

endpackage

// File: rtl/lcd_pix_mem.sv
// lcd_pix_mem: single write port, asynchronous read pixel array (no reset)
module lcd_pix_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 36,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // pixel write; storage is left unreset so it maps onto plain memory
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: image loader and WIN x WIN window streamer with shift, home and mirror commands
module lcd_win_ctrl
    import lcd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int ADDR_W = bits_for(N_PIX - 1);
    localparam int OX_MAX = IMG_W - WIN;
    localparam int OY_MAX = IMG_H - WIN;
    localparam int OX0    = origin0(IMG_W, WIN);
    localparam int OY0    = origin0(IMG_H, WIN);
    localparam int OXW    = bits_for(OX_MAX);
    localparam int OYW    = bits_for(OY_MAX);
    localparam int CW     = bits_for(WIN);

    state_t            state;
    logic [OXW-1:0]    ox, nox, eox;
    logic [OYW-1:0]    oy, noy, eoy;
    logic              mirror, nmir, emir;
    logic [ADDR_W-1:0] k, addr;
    logic [CW-1:0]     r, c, er, ec, nr, nc, col;
    logic [DW-1:0]     mem_rdata, pix;
    logic              accept, load_last, first, done, emit;

    lcd_pix_mem #(.DW(DW), .DEPTH(N_PIX), .AW(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (state == LOAD),
        .waddr (k),
        .wdata (datain),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    // origin and mirror implied by the incoming command, with edge clamping
    always_comb begin
        nox  = ox;
        noy  = oy;
        nmir = mirror;
        case (cmd)
            CMD_LOAD:   begin nox = OXW'(OX0); noy = OYW'(OY0); end
            CMD_RIGHT:  nox = (ox == OXW'(OX_MAX)) ? ox : ox + OXW'(1);
            CMD_LEFT:   nox = (ox == '0) ? ox : ox - OXW'(1);
            CMD_UP:     noy = (oy == '0) ? oy : oy - OYW'(1);
            CMD_DOWN:   noy = (oy == OYW'(OY_MAX)) ? oy : oy + OYW'(1);
            CMD_HOME:   begin nox = '0; noy = '0; end
            CMD_MIRROR: nmir = ~mirror;
            default:    ;
        endcase
    end

    // the first pixel of a burst is emitted on the edge that starts it, using the freshly updated origin
    assign accept    = cmd_valid && !busy;
    assign load_last = (state == LOAD) && (k == ADDR_W'(N_PIX - 1));
    assign first     = (accept && cmd != CMD_LOAD) || load_last;
    assign done      = (state == OUT) && (r == CW'(WIN));
    assign emit      = first || (state == OUT && !done);
    assign er        = first ? '0 : r;
    assign ec        = first ? '0 : c;
    assign eox       = accept ? nox : ox;
    assign eoy       = accept ? noy : oy;
    assign emir      = accept ? nmir : mirror;
    assign col       = emir ? CW'(WIN - 1) - ec : ec;
    assign addr      = (ADDR_W'(eoy) + ADDR_W'(er)) * ADDR_W'(IMG_W) + ADDR_W'(eox) + ADDR_W'(col);
    assign nr        = (ec == CW'(WIN - 1)) ? er + CW'(1) : er;
    assign nc        = (ec == CW'(WIN - 1)) ? '0 : ec + CW'(1);
    // bypass the pixel being written this cycle so a window over the last loaded pixel reads correctly
    assign pix       = (state == LOAD && k == addr) ? datain : mem_rdata;

    // control FSM with registered outputs; origin and mirror commit on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            dataout      <= '0;
            ox           <= OXW'(OX0);
            oy           <= OYW'(OY0);
            mirror       <= 1'b0;
            k            <= '0;
            r            <= '0;
            c            <= '0;
        end else begin
            if (accept) begin
                ox     <= nox;
                oy     <= noy;
                mirror <= nmir;
                busy   <= 1'b1;
                k      <= '0;
                state  <= (cmd == CMD_LOAD) ? LOAD : OUT;
            end
            if (state == LOAD) k <= k + ADDR_W'(1);
            if (load_last) state <= OUT;
            if (emit) begin
                dataout      <= pix;
                output_valid <= 1'b1;
                r            <= nr;
                c            <= nc;
            end
            if (done) begin
                state        <= IDLE;
                busy         <= 1'b0;
                output_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb_lcd_win_ctrl: scoreboard bench for the LCD window controller (6x6/3 and 8x4/2 instances)
module tb_lcd_win_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cmd_valid, output_valid, busy;
    logic [7:0] datain, dataout;
    logic [2:0] cmd;
    logic       b_reset, b_cmd_valid, b_output_valid, b_busy;
    logic [7:0] b_datain, b_dataout;
    logic [2:0] b_cmd;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    int ea, eb;

    lcd_win_ctrl #(.DW(8), .IMG_W(6), .IMG_H(6), .WIN(3)) u_a (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
        .dataout(dataout), .output_valid(output_valid), .busy(busy)
    );

    lcd_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(4), .WIN(2)) u_b (
        .clk(clk), .reset(b_reset), .datain(b_datain), .cmd(b_cmd), .cmd_valid(b_cmd_valid),
        .dataout(b_dataout), .output_valid(b_output_valid), .busy(b_busy)
    );

    // scoreboard for instance a
    always @(negedge clk) begin
        if (output_valid === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_output dataout=%0d required no output", dataout);
            end else begin
                ea = qa.pop_front();
                if (dataout !== 8'(ea)) begin
                    errors++;
                    $display("FAIL a_pixel dataout=%0d required %0d", dataout, ea);
                end
            end
        end
    end

    // scoreboard for instance b
    always @(negedge clk) begin
        if (b_output_valid === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_output dataout=%0d required no output", b_dataout);
            end else begin
                eb = qb.pop_front();
                if (b_dataout !== 8'(eb)) begin
                    errors++;
                    $display("FAIL b_pixel dataout=%0d required %0d", b_dataout, eb);
                end
            end
        end
    end

    task automatic push_win(input bit b, input int w, input int win, input int ox, input int oy, input bit mir);
        for (int r = 0; r < win; r++)
            for (int c = 0; c < win; c++) begin
                int v;
                v = (oy + r) * w + ox + (mir ? win - 1 - c : c);
                if (b) qb.push_back(v);
                else qa.push_back(v);
            end
    endtask

    task automatic issue(input bit b, input logic [2:0] c);
        @(posedge clk); #1;
        if (b) begin b_cmd = c; b_cmd_valid = 1'b1; end
        else begin cmd = c; cmd_valid = 1'b1; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit b);
        int n;
        n = 0;
        while ((b ? (b_busy !== 1'b0 || b_output_valid !== 1'b0) : (busy !== 1'b0 || output_valid !== 1'b0)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout busy still high after 300 cycles, required low", b ? "b" : "a");
        end
    endtask

    task automatic check_drained(input bit b, input string name);
        checks++;
        if ((b ? qb.size() : qa.size()) != 0) begin
            errors++;
            $display("FAIL %s pending=%0d required 0", name, b ? qb.size() : qa.size());
        end
    endtask

    task automatic load_image(input bit b, input int n);
        @(posedge clk); #1;
        if (b) begin b_cmd = 3'd1; b_cmd_valid = 1'b1; end
        else begin cmd = 3'd1; cmd_valid = 1'b1; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        if (b) b_datain = 8'd0; else datain = 8'd0;
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            if (b) b_datain = 8'(k); else datain = 8'(k);
        end
        @(negedge clk);
        checks++;
        if ((b ? b_output_valid : output_valid) !== 1'b0 || (b ? b_busy : busy) !== 1'b1) begin
            errors++;
            $display("FAIL load_phase output_valid=%b busy=%b required 0 1",
                     b ? b_output_valid : output_valid, b ? b_busy : busy);
        end
        @(negedge clk);
        checks++;
        if ((b ? b_output_valid : output_valid) !== 1'b1) begin
            errors++;
            $display("FAIL load_first_output output_valid=%b required 1", b ? b_output_valid : output_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; b_reset = 1'b1;
        cmd_valid = 1'b0; b_cmd_valid = 1'b0;
        cmd = 3'd0; b_cmd = 3'd0;
        datain = 8'd0; b_datain = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b0 || busy !== 1'b0 || dataout !== 8'd0) begin
            errors++;
            $display("FAIL reset_a ov=%b busy=%b dataout=%0d required 0 0 0", output_valid, busy, dataout);
        end
        checks++;
        if (b_output_valid !== 1'b0 || b_busy !== 1'b0 || b_dataout !== 8'd0) begin
            errors++;
            $display("FAIL reset_b ov=%b busy=%b dataout=%0d required 0 0 0", b_output_valid, b_busy, b_dataout);
        end
        reset = 1'b0; b_reset = 1'b0;
    endtask

    task automatic test_load();
        qa.push_back(14); qa.push_back(15); qa.push_back(16);
        qa.push_back(20); qa.push_back(21); qa.push_back(22);
        qa.push_back(26); qa.push_back(27); qa.push_back(28);
        load_image(1'b0, 36);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || output_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_last_output busy=%b ov=%b required 1 1", busy, output_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || output_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_busy_fall busy=%b ov=%b required 0 0", busy, output_valid);
        end
        check_drained(1'b0, "load_drained");
    endtask

    task automatic test_shift_right();
        push_win(1'b0, 6, 3, 3, 2, 1'b0);
        issue(1'b0, 3'd2);
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_latency ov=%b busy=%b required 1 1", output_valid, busy);
        end
        @(negedge clk);
        @(posedge clk); #1;
        cmd = 3'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(1'b0);
        check_drained(1'b0, "right_drained");
        push_win(1'b0, 6, 3, 3, 2, 1'b0);
        issue(1'b0, 3'd2);
        wait_idle(1'b0);
        repeat (3) @(negedge clk);
        check_drained(1'b0, "right_clamp_drained");
    endtask

    task automatic test_up_mirror();
        for (int i = 0; i < 3; i++) begin
            push_win(1'b0, 6, 3, 3, (i < 2) ? 1 - i : 0, 1'b0);
            issue(1'b0, 3'd4);
            wait_idle(1'b0);
        end
        push_win(1'b0, 6, 3, 3, 0, 1'b1);
        issue(1'b0, 3'd7);
        wait_idle(1'b0);
        check_drained(1'b0, "up_mirror_drained");
    endtask

    task automatic test_home();
        push_win(1'b0, 6, 3, 0, 0, 1'b1);
        issue(1'b0, 3'd6);
        wait_idle(1'b0);
        push_win(1'b0, 6, 3, 0, 0, 1'b0);
        issue(1'b0, 3'd7);
        wait_idle(1'b0);
        push_win(1'b0, 6, 3, 0, 0, 1'b0);
        issue(1'b0, 3'd0);
        wait_idle(1'b0);
        check_drained(1'b0, "home_drained");
    endtask

    task automatic test_small();
        qb.push_back(11); qb.push_back(12); qb.push_back(19); qb.push_back(20);
        load_image(1'b1, 32);
        wait_idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            push_win(1'b1, 8, 2, 3, 2, 1'b0);
            issue(1'b1, 3'd5);
            wait_idle(1'b1);
        end
        check_drained(1'b1, "small_drained");
    endtask

    task automatic test_mid_reset();
        push_win(1'b0, 6, 3, 0, 0, 1'b1);
        issue(1'b0, 3'd7);
        wait_idle(1'b0);
        qa.push_back(2); qa.push_back(1); qa.push_back(0); qa.push_back(8);
        @(posedge clk); #1;
        cmd = 3'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b0 || busy !== 1'b0 || dataout !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset ov=%b busy=%b dataout=%0d required 0 0 0", output_valid, busy, dataout);
        end
        reset = 1'b0;
        check_drained(1'b0, "mid_reset_drained");
        push_win(1'b0, 6, 3, 2, 2, 1'b0);
        issue(1'b0, 3'd0);
        wait_idle(1'b0);
        check_drained(1'b0, "after_reset_drained");
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_up_mirror();
        test_home();
        test_small();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
Parametrised successor of the contest LCD window controller. Loads an IMG_W x IMG_H image into internal storage, one pixel per cycle. On each command it streams out a WIN x WIN window whose top-left origin moves under shift commands. New over the fixed 6x6/3x3 block: arbitrary image, window and pixel sizes; a home command; and a horizontal-mirror output mode.

Parameters:
DW, 8, pixel width in bits
IMG_W, 6, image width in pixels (>= WIN)
IMG_H, 6, image height in pixels (>= WIN)
WIN, 3, window edge in pixels (>= 1)

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
datain  in  DW  pixel input during load, raster order
cmd  in  3  command code
cmd_valid  in  1  command strobe
dataout  out  DW  window pixel output, registered
output_valid  out  1  dataout qualifier
busy  out  1  high while a command executes; commands ignored

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: dataout=0, output_valid=0, busy=0, state=IDLE, mirror=0, origin=(OX0,OY0).
- OX0=(IMG_W-WIN+1)/2, OY0=(IMG_H-WIN+1)/2, integer divide. For 6x6/3 this gives (2,2).
- Pixel memory is not reset. Its contents stay undefined until the first load.
- Acceptance: a command is taken at posedge t when cmd_valid=1 and busy=0. busy=1 from t+1. cmd_valid while busy=1 is ignored.
- Commands:
  - 0 Reflash: no change.
  - 1 Load: origin=(OX0,OY0), mirror unchanged.
  - 2 Right: OX=min(OX+1, IMG_W-WIN).
  - 3 Left: OX=max(OX-1, 0).
  - 4 Up: OY=max(OY-1, 0).
  - 5 Down: OY=min(OY+1, IMG_H-WIN).
  - 6 Home: origin=(0,0).
  - 7 Mirror: toggle mirror.
- Shifts clamp silently at the edges. There is no wrap-around.
- Each command ends with one output burst. Load first performs its load phase.
- State machine:
  - IDLE -> LOAD on accepted cmd 1.
  - IDLE -> OUT on any other accepted cmd.
  - LOAD -> OUT after the IMG_W*IMG_H-th pixel.
  - OUT -> IDLE after WIN*WIN outputs.
- LOAD: pixel k (k=0..N-1, N=IMG_W*IMG_H) is sampled from datain at posedge t+1+k into address k, raster order (row*IMG_W+col).
- OUT:
  - output_valid=1 for exactly WIN*WIN consecutive cycles; dataout changes only with output_valid.
  - Order: rows top to bottom. Within a row, columns left to right, or right to left when mirror=1.
  - Pixel (r,c) address = (OY+r)*IMG_W + (OX+c).
  - For non-load commands, output_valid is high for cycles t+1..t+WIN*WIN. For load, for cycles t+N+1..t+N+WIN*WIN.
  - Origin/mirror updates take effect before the first output of that burst.
- busy and output_valid fall at the same posedge after the last output. A new command may be accepted on that same cycle, the first with busy=0.
- Widths:
  - Origin counters are $clog2 of range+1; row/col counters are $clog2(WIN+1).
  - The address is $clog2(N) bits; compute in full width, no truncation.
  - Memory read is combinational or 1-cycle. If 1-cycle, pipeline it so the cycle timing above still holds.
- Reset mid-LOAD or mid-OUT: back to IDLE next cycle. All outputs and origin/mirror return to reset values. Partially loaded memory is kept but undefined.
- Degenerate WIN=IMG_W: Right and Left are no-ops. Same for WIN=IMG_H with Up and Down.

Decomposition:
- Shared package lcd_pkg:
  - cmd codes CMD_REFLASH..CMD_MIRROR.
  - State enum IDLE/LOAD/OUT.
  - Localparams N_PIX, ADDR_W, OX_MAX, OY_MAX, OX0, OY0 as functions of the parameters.
- One sub-module, lcd_pix_mem: N_PIX x DW single-port write / asynchronous-read register array.
- FSM, origin and counters live in lcd_win_ctrl.

Test Plan:
1. Defaults (6x6, WIN 3). Load 0..35, then 9 outputs → 14,15,16,20,21,22,26,27,28. busy low on the cycle after output 28.
2. Two cmd 2 → origin (3,2), outputs 15,16,17,21,22,23,27,28,29 both times (second clamped). cmd_valid pulsed during busy → no extra burst.
3. From (3,2), three cmd 4 → last burst 3,4,5,9,10,11,15,16,17. Then cmd 7 → 5,4,3,11,10,9,17,16,15.
4. cmd 6 with mirror still on → 2,1,0,8,7,6,14,13,12. cmd 7, then cmd 0 → 0,1,2,6,7,8,12,13,14.
5. IMG_W=8, IMG_H=4, WIN=2. Load 0..31 → origin (3,1), outputs 11,12,19,20. Then three cmd 5 → clamped at OY=2, outputs 19,20,27,28.
6. Assert reset mid-OUT (after 4 outputs) → next cycle output_valid=0, busy=0. Then cmd 0 → default-origin window of the retained image.
